// File: rtl/enc_6to3_pending.sv
// Registered 6-to-3 priority encoder with a pending-request register and a
// valid/ready offer; the FSM state is carried by the valid flag itself.
module enc_6to3_pending #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         clr,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic [N-1:0] pend,
    output logic         lost
);

    // state | meaning
    // IDLE  | no offer outstanding, valid=0, y keeps its last code
    // OFFER | y holds a pending index, valid=1, waits for ready
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] y_next;
    logic [N-1:0] pend_next;
    logic [N-1:0] pend_reg_next;
    logic         lost_next;

    logic         acc;
    logic [N-1:0] served;
    logic [N-1:0] cap;
    logic         any_next;
    logic         dup;

    function automatic logic [W-1:0] prio(input logic [N-1:0] v);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) p = W'(i);
        end
        return p;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [W-1:0] code);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (W'(i) == code) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign acc       = valid & ready;
    assign served    = acc ? onehot(y) : '0;
    assign cap       = req & {N{en}};
    assign pend_next = (pend & ~served) | cap;
    assign any_next  = |pend_next;
    // A served bit re-requested in the same cycle is a fresh request, not a loss.
    assign dup       = |(cap & pend & ~served);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            pend  <= '0;
            lost  <= 1'b0;
        end else begin
            state <= state_next;
            y     <= y_next;
            pend  <= pend_reg_next;
            lost  <= lost_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = any_next ? OFFER : IDLE;
                OFFER:   if (ready) state_next = any_next ? OFFER : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // No preemption: y only reloads when idle or when the current code is taken.
    always_comb begin
        y_next        = y;
        pend_reg_next = pend_next;
        lost_next     = dup;
        if (clr) begin
            y_next        = '0;
            pend_reg_next = '0;
            lost_next     = 1'b0;
        end else if (((state == IDLE) || acc) && any_next) begin
            y_next = prio(pend_next);
        end
    end

    assign valid = (state == OFFER);

endmodule

// File: tb/tb_enc_6to3_pending.sv
// Directed bench for enc_6to3_pending: each task drives one scenario and checks
// {y, valid, pend, lost} against hand-computed values one cycle at a time.
module tb_enc_6to3_pending;

    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] req;
    logic       clr;
    logic       ready;
    logic [2:0] y;
    logic       valid;
    logic [5:0] pend;
    logic       lost;

    int checks   = 0;
    int failures = 0;

    enc_6to3_pending dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .clr   (clr),
        .ready (ready),
        .y     (y),
        .valid (valid),
        .pend  (pend),
        .lost  (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = '0; clr = 1'b0; ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({y, valid, pend, lost} !== {3'd0, 1'b0, 6'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got y=%0d valid=%b pend=%b lost=%b want 0/0/000000/0",
                         i, y, valid, pend, lost);
            end
        end
        req = 6'b000001;
        tick();
        req = '0;
        checks++;
        if ({y, valid, pend} !== {3'd0, 1'b1, 6'b000001}) begin
            failures++;
            $display("FAIL reset_preload got y=%0d valid=%b pend=%b want 0/1/000001", y, valid, pend);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({y, valid, pend, lost} !== {3'd0, 1'b0, 6'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async got y=%0d valid=%b pend=%b lost=%b want 0/0/000000/0",
                     y, valid, pend, lost);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({valid, pend} !== {1'b0, 6'b0}) begin
            failures++;
            $display("FAIL reset_after got valid=%b pend=%b want 0/000000", valid, pend);
        end
    endtask

    task automatic test_single();
        en = 1'b1; ready = 1'b1; req = 6'b000100;
        tick();
        req = '0;
        checks++;
        if ({y, valid, pend} !== {3'd2, 1'b1, 6'b000100}) begin
            failures++;
            $display("FAIL single_offer got y=%0d valid=%b pend=%b want 2/1/000100", y, valid, pend);
        end
        tick();
        checks++;
        if ({valid, pend} !== {1'b0, 6'b0}) begin
            failures++;
            $display("FAIL single_drain got valid=%b pend=%b want 0/000000", valid, pend);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_y [3];
        logic [5:0] exp_p [3];
        exp_y[0] = 3'd5; exp_p[0] = 6'b100101;
        exp_y[1] = 3'd2; exp_p[1] = 6'b000101;
        exp_y[2] = 3'd0; exp_p[2] = 6'b000001;
        en = 1'b1; ready = 1'b1; req = 6'b100101;
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({y, valid, pend} !== {exp_y[i], 1'b1, exp_p[i]}) begin
                failures++;
                $display("FAIL b2b_step%0d got y=%0d valid=%b pend=%b want %0d/1/%b",
                         i, y, valid, pend, exp_y[i], exp_p[i]);
            end
            tick();
        end
        checks++;
        if ({valid, pend} !== {1'b0, 6'b0}) begin
            failures++;
            $display("FAIL b2b_drain got valid=%b pend=%b want 0/000000", valid, pend);
        end
        // accept and re-request of the same bit keeps it offered, no loss
        req = 6'b001000;
        tick();
        checks++;
        if ({y, valid, pend, lost} !== {3'd3, 1'b1, 6'b001000, 1'b0}) begin
            failures++;
            $display("FAIL rereq_load got y=%0d valid=%b pend=%b lost=%b want 3/1/001000/0",
                     y, valid, pend, lost);
        end
        tick();
        req = '0;
        checks++;
        if ({y, valid, pend, lost} !== {3'd3, 1'b1, 6'b001000, 1'b0}) begin
            failures++;
            $display("FAIL rereq_keep got y=%0d valid=%b pend=%b lost=%b want 3/1/001000/0",
                     y, valid, pend, lost);
        end
        tick();
        checks++;
        if ({valid, pend} !== {1'b0, 6'b0}) begin
            failures++;
            $display("FAIL rereq_drain got valid=%b pend=%b want 0/000000", valid, pend);
        end
    endtask

    task automatic test_backpressure();
        en = 1'b1; ready = 1'b0; req = 6'b000100;
        tick();
        checks++;
        if ({y, valid, pend} !== {3'd2, 1'b1, 6'b000100}) begin
            failures++;
            $display("FAIL bp_offer got y=%0d valid=%b pend=%b want 2/1/000100", y, valid, pend);
        end
        req = 6'b100000;
        tick();
        req = '0;
        checks++;
        if ({y, valid, pend} !== {3'd2, 1'b1, 6'b100100}) begin
            failures++;
            $display("FAIL bp_nopreempt got y=%0d valid=%b pend=%b want 2/1/100100", y, valid, pend);
        end
        tick();
        checks++;
        if ({y, valid, pend} !== {3'd2, 1'b1, 6'b100100}) begin
            failures++;
            $display("FAIL bp_hold got y=%0d valid=%b pend=%b want 2/1/100100", y, valid, pend);
        end
        ready = 1'b1;
        tick();
        checks++;
        if ({y, valid, pend} !== {3'd5, 1'b1, 6'b100000}) begin
            failures++;
            $display("FAIL bp_next got y=%0d valid=%b pend=%b want 5/1/100000", y, valid, pend);
        end
        tick();
        checks++;
        if ({valid, pend} !== {1'b0, 6'b0}) begin
            failures++;
            $display("FAIL bp_drain got valid=%b pend=%b want 0/000000", valid, pend);
        end
    endtask

    task automatic test_enable();
        en = 1'b0; ready = 1'b1; req = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid, pend, lost} !== {1'b0, 6'b0, 1'b0}) begin
                failures++;
                $display("FAIL en_off cyc=%0d got valid=%b pend=%b lost=%b want 0/000000/0",
                         i, valid, pend, lost);
            end
        end
        en = 1'b1; req = 6'b000001;
        tick();
        req = '0;
        checks++;
        if ({y, valid} !== {3'd0, 1'b1}) begin
            failures++;
            $display("FAIL en_on got y=%0d valid=%b want 0/1", y, valid);
        end
        tick();
        checks++;
        if ({valid, pend} !== {1'b0, 6'b0}) begin
            failures++;
            $display("FAIL en_drain got valid=%b pend=%b want 0/000000", valid, pend);
        end
    endtask

    task automatic test_lost_clear();
        en = 1'b1; ready = 1'b0; req = 6'b001000;
        tick();
        checks++;
        if ({y, valid, pend, lost} !== {3'd3, 1'b1, 6'b001000, 1'b0}) begin
            failures++;
            $display("FAIL dup_first got y=%0d valid=%b pend=%b lost=%b want 3/1/001000/0",
                     y, valid, pend, lost);
        end
        tick();
        req = '0;
        checks++;
        if ({y, valid, pend, lost} !== {3'd3, 1'b1, 6'b001000, 1'b1}) begin
            failures++;
            $display("FAIL dup_lost got y=%0d valid=%b pend=%b lost=%b want 3/1/001000/1",
                     y, valid, pend, lost);
        end
        tick();
        checks++;
        if ({pend, lost} !== {6'b001000, 1'b0}) begin
            failures++;
            $display("FAIL dup_pulse got pend=%b lost=%b want 001000/0", pend, lost);
        end
        clr = 1'b1; ready = 1'b1; req = 6'b010000;
        tick();
        clr = 1'b0; req = '0;
        checks++;
        if ({y, valid, pend, lost} !== {3'd0, 1'b0, 6'b0, 1'b0}) begin
            failures++;
            $display("FAIL clr got y=%0d valid=%b pend=%b lost=%b want 0/0/000000/0",
                     y, valid, pend, lost);
        end
        tick();
        checks++;
        if ({valid, pend} !== {1'b0, 6'b0}) begin
            failures++;
            $display("FAIL clr_after got valid=%b pend=%b want 0/000000", valid, pend);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_enable();
        test_lost_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
